audio_route_sequencer: RTL

- Control-side counterpart of the effect routing mux: turns an ordered effect chain request into the six 3-bit source selects the mux consumes.
- Applies a click-free reconfiguration sequence: fade the final stereo output down, swap selects, fade back up.
- Sits between the UI/config logic and the routing mux; also carries the post-mux stereo output path so it can apply the gain ramp.

---
 rtl/audio_route_sequencer_pkg.sv | 85 ++++++++
 rtl/audio_route_sequencer_gain_ramp.sv | 61 ++++++
 rtl/audio_route_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/audio_route_sequencer_pkg.sv
// Shared types for the effect routing sequencer: source IDs, FSM states,
// the six-select bundle and the chain validation/mapping helpers.
package audio_route_pkg;

    localparam int unsigned MAX_CHAIN = 5;

    typedef enum logic [2:0] {
        SRC_BASE       = 3'b000,
        SRC_DELAY      = 3'b001,
        SRC_REVERB     = 3'b010,
        SRC_FILTER     = 3'b011,
        SRC_DISTORTION = 3'b100,
        SRC_CRUSH      = 3'b101,
        SRC_NONE       = 3'b111
    } src_id_t;

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        SWAP,
        FADE_IN
    } route_state_t;

    typedef struct packed {
        src_id_t delay_src;
        src_id_t crush_src;
        src_id_t dist_src;
        src_id_t filter_src;
        src_id_t reverb_src;
        src_id_t out_src;
    } route_sel_t;

    localparam route_sel_t SEL_RESET = '{
        delay_src:  SRC_NONE,
        crush_src:  SRC_NONE,
        dist_src:   SRC_NONE,
        filter_src: SRC_NONE,
        reverb_src: SRC_NONE,
        out_src:    SRC_BASE
    };

    function automatic logic chain_valid(input logic [3*MAX_CHAIN-1:0] chain,
                                         input logic [2:0] len);
        logic [7:0] seen;
        logic [2:0] id;
        logic       ok;
        seen = '0;
        ok   = (len <= 3'(MAX_CHAIN));
        for (int unsigned i = 0; i < MAX_CHAIN; i++) begin
            id = chain[3*i +: 3];
            if (i < 32'(len)) begin
                if (id == 3'd0 || id > 3'd5 || seen[id]) ok = 1'b0;
                seen[id] = 1'b1;
            end
        end
        return ok;
    endfunction

    // Each used effect is fed by the previous slot; slot 0 is fed by the dry base.
    function automatic route_sel_t chain_to_sel(input logic [3*MAX_CHAIN-1:0] chain,
                                                input logic [2:0] len);
        route_sel_t sel;
        src_id_t    prev;
        src_id_t    id;
        sel  = SEL_RESET;
        prev = SRC_BASE;
        for (int unsigned i = 0; i < MAX_CHAIN; i++) begin
            id = src_id_t'(chain[3*i +: 3]);
            if (i < 32'(len)) begin
                case (id)
                    SRC_DELAY:      sel.delay_src  = prev;
                    SRC_REVERB:     sel.reverb_src = prev;
                    SRC_FILTER:     sel.filter_src = prev;
                    SRC_DISTORTION: sel.dist_src   = prev;
                    SRC_CRUSH:      sel.crush_src  = prev;
                    default:        ;
                endcase
                prev = id;
            end
        end
        sel.out_src = prev;
        return sel;
    endfunction

endpackage

// File: rtl/audio_route_sequencer_gain_ramp.sv
// Stereo gain ramp: step register, (sample * step) >>> RAMP_LOG2 and a
// one-cycle registered valid/sample pipeline.
module audio_gain_ramp #(
    parameter int unsigned RAMP_LOG2 = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_up,
    input  logic                 i_down,
    input  logic signed [15:0]   i_sample_l,
    input  logic signed [15:0]   i_sample_r,
    input  logic                 i_valid,
    output logic [RAMP_LOG2:0]   o_step,
    output logic signed [15:0]   o_sample_l,
    output logic signed [15:0]   o_sample_r,
    output logic                 o_valid
);

    localparam logic [RAMP_LOG2:0] RAMP_LEN = {1'b1, {RAMP_LOG2{1'b0}}};
    localparam int unsigned        PW       = 16 + RAMP_LOG2 + 2;

    logic [RAMP_LOG2:0]    r_step;
    logic signed [15:0]    r_sample_l;
    logic signed [15:0]    r_sample_r;
    logic                  r_valid;
    logic signed [PW-1:0]  w_prod_l;
    logic signed [PW-1:0]  w_prod_r;
    logic signed [15:0]    w_gain_l;
    logic signed [15:0]    w_gain_r;

    // Zero-extend step so the product stays signed and full width.
    assign w_prod_l = i_sample_l * $signed({1'b0, r_step});
    assign w_prod_r = i_sample_r * $signed({1'b0, r_step});
    assign w_gain_l = 16'(w_prod_l >>> RAMP_LOG2);
    assign w_gain_r = 16'(w_prod_r >>> RAMP_LOG2);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_step     <= RAMP_LEN;
            r_sample_l <= '0;
            r_sample_r <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_sample_l <= w_gain_l;
                r_sample_r <= w_gain_r;
                if (i_down && r_step != '0)
                    r_step <= r_step - 1'b1;
                else if (i_up && r_step != RAMP_LEN)
                    r_step <= r_step + 1'b1;
            end
        end
    end

    assign o_step     = r_step;
    assign o_sample_l = r_sample_l;
    assign o_sample_r = r_sample_r;
    assign o_valid    = r_valid;

endmodule

// File: rtl/audio_route_sequencer.sv
// Effect chain request -> six routing selects, swapped via a fade-out/fade-in
// sequence when AUDIO_ROUTE_FADE_EN is defined, otherwise via a single SWAP cycle.
module audio_route_sequencer
    import audio_route_pkg::*;
#(
    parameter int unsigned RAMP_LOG2 = 6
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [14:0]         req_chain,
    input  logic [2:0]          req_len,
    input  logic                req_valid,
    output logic                req_ready,
    output logic                cfg_err,
    output logic                busy,
    output logic [2:0]          delay_src,
    output logic [2:0]          crush_src,
    output logic [2:0]          distortion_src,
    output logic [2:0]          filter_src,
    output logic [2:0]          reverb_src,
    output logic [2:0]          output_src,
    input  logic signed [15:0]  sample_l_in,
    input  logic signed [15:0]  sample_r_in,
    input  logic                valid_in,
    output logic signed [15:0]  sample_l_out,
    output logic signed [15:0]  sample_r_out,
    output logic                valid_out
);

    localparam logic [RAMP_LOG2:0] RAMP_LEN = {1'b1, {RAMP_LOG2{1'b0}}};

    route_state_t       r_state;
    route_state_t       w_next;
    route_sel_t         r_live;
    route_sel_t         r_shadow;
    route_sel_t         w_req_sel;
    logic               r_cfg_err;
    logic               w_accept;
    logic               w_req_ok;
    logic               w_up;
    logic               w_down;
    logic [RAMP_LOG2:0] w_step;

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign cfg_err   = r_cfg_err;
    assign w_accept  = req_valid && req_ready;
    assign w_req_ok  = chain_valid(req_chain, req_len);
    assign w_req_sel = chain_to_sel(req_chain, req_len);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= IDLE;
            r_live    <= SEL_RESET;
            r_shadow  <= SEL_RESET;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cfg_err <= w_accept && !w_req_ok;
            if (w_accept && w_req_ok) r_shadow <= w_req_sel;
            if (r_state == SWAP)      r_live   <= r_shadow;
        end
    end

    always_comb begin
        w_next = r_state;
        w_up   = 1'b0;
        w_down = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_req_ok) begin
`ifdef AUDIO_ROUTE_FADE_EN
                    w_next = FADE_OUT;
`else
                    w_next = SWAP;
`endif
                end
            end
            FADE_OUT: begin
                if (w_step == '0) w_next = SWAP;
                else              w_down = 1'b1;
            end
            SWAP: begin
`ifdef AUDIO_ROUTE_FADE_EN
                w_next = FADE_IN;
`else
                w_next = IDLE;
`endif
            end
            FADE_IN: begin
                if (w_step == RAMP_LEN) w_next = IDLE;
                else                    w_up   = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    audio_gain_ramp #(
        .RAMP_LOG2(RAMP_LOG2)
    ) u_gain (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_up       (w_up),
        .i_down     (w_down),
        .i_sample_l (sample_l_in),
        .i_sample_r (sample_r_in),
        .i_valid    (valid_in),
        .o_step     (w_step),
        .o_sample_l (sample_l_out),
        .o_sample_r (sample_r_out),
        .o_valid    (valid_out)
    );

    assign delay_src      = r_live.delay_src;
    assign crush_src      = r_live.crush_src;
    assign distortion_src = r_live.dist_src;
    assign filter_src     = r_live.filter_src;
    assign reverb_src     = r_live.reverb_src;
    assign output_src     = r_live.out_src;

endmodule
